small_alu_issue: RTL and testbench

- Issue/writeback stage wrapped around smallALU.
- Owns the 4x16 register file and accepts 16-bit instructions over a valid/ready handshake.
- Decodes each instruction into smallALU's R/select1_reg/select2_reg/sig/op inputs, then writes the ALU's 8-bit result back, zero-extended, into the destination register.
- Also executes load-immediate-low/high directly into the register file.

---
 rtl/small_alu_issue.sv | 86 ++++++++
 tb/tb_small_alu_issue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/small_alu_issue.sv
// small_alu_issue: issue/writeback stage around smallALU with a 4x16 register file,
// one-cycle ALU execute and direct load-immediate-low/high writes.
module small_alu_issue #(
  parameter int          CNT_W   = 16,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              flush,
  output logic [3:0][15:0]  alu_R,
  output logic [1:0]        alu_sel1,
  output logic [1:0]        alu_sel2,
  output logic              alu_sig,
  output logic              alu_op,
  input  logic [7:0]        alu_out,
  output logic              wb_valid,
  output logic [1:0]        wb_addr,
  output logic [15:0]       wb_data,
  output logic [CNT_W-1:0]  retired
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t             state_q;
  logic [3:0][15:0]   rf_q;
  logic [1:0]         rd_q, sel1_q, sel2_q, wb_addr_q;
  logic               sig_q, op_q, wb_valid_q;
  logic [15:0]        wb_data_q;
  logic [CNT_W-1:0]   ret_q;
  logic [1:0]         opc, addr_d;
  logic [15:0]        data_d;
  logic               accept, go_d, wr_d, ret_d;
  assign instr_ready = (state_q == IDLE) && !flush;
  assign alu_R       = rf_q;
  assign alu_sel1    = sel1_q;
  assign alu_sel2    = sel2_q;
  assign alu_sig     = sig_q;
  assign alu_op      = op_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign retired     = ret_q;
  // EXEC retires the latched ALU op; IDLE retires loads and NOPs on acceptance
  always_comb begin
    opc    = instr[15:14];
    accept = instr_valid && instr_ready;
    go_d   = accept && opc == 2'b00;
    wr_d   = (state_q == EXEC) ? !flush : accept && (opc == 2'b01 || opc == 2'b10);
    ret_d  = wr_d || (accept && opc == 2'b11);
    addr_d = (state_q == EXEC) ? rd_q : instr[11:10];
    data_d = (state_q == EXEC) ? {8'h00, alu_out} :
             (opc == 2'b01)    ? {8'h00, instr[7:0]} : {instr[7:0], rf_q[addr_d][7:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rf_q       <= {4{RST_VAL}};
      rd_q       <= '0;
      sel1_q     <= '0;
      sel2_q     <= '0;
      sig_q      <= 1'b0;
      op_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      ret_q      <= '0;
    end else begin
      state_q    <= go_d ? EXEC : IDLE;
      wb_valid_q <= wr_d;
      if (wr_d) begin
        rf_q[addr_d] <= data_d;
        wb_addr_q    <= addr_d;
        wb_data_q    <= data_d;
      end
      if (ret_d) ret_q <= ret_q + CNT_W'(1);
      if (go_d) begin
        rd_q   <= instr[11:10];
        sel1_q <= instr[9:8];
        sel2_q <= instr[7:6];
        op_q   <= instr[13];
        sig_q  <= instr[12];
      end
    end
  end
endmodule

// File: tb/tb_small_alu_issue.sv
// tb_small_alu_issue: directed stimulus with a per-cycle behavioural model check
// plus hand-computed literal expectations; a CNT_W=4 instance covers counter wrap.
module tb_small_alu_issue;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] instr;
  logic instr_valid, flush;
  logic [7:0] alu_out;
  logic instr_ready, alu_sig, alu_op, wb_valid;
  logic [3:0][15:0] alu_R;
  logic [1:0] alu_sel1, alu_sel2, wb_addr;
  logic [15:0] wb_data, retired;
  logic [15:0] instr4;
  logic valid4, ready4, sig4, op4, wbv4;
  logic [3:0][15:0] alu_R4;
  logic [1:0] s1_4, s2_4, wba4;
  logic [15:0] wbd4;
  logic [3:0] ret4;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  small_alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .alu_R(alu_R), .alu_sel1(alu_sel1),
    .alu_sel2(alu_sel2), .alu_sig(alu_sig), .alu_op(alu_op), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
  );
  small_alu_issue #(.CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .instr(instr4), .instr_valid(valid4),
    .instr_ready(ready4), .flush(1'b0), .alu_R(alu_R4), .alu_sel1(s1_4),
    .alu_sel2(s2_4), .alu_sig(sig4), .alu_op(op4), .alu_out(8'h00),
    .wb_valid(wbv4), .wb_addr(wba4), .wb_data(wbd4), .retired(ret4)
  );
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction
  // behavioural model: architectural registers, a pending-ALU flag, last writeback
  logic [15:0] m_r [4] = '{default: 16'h0000};
  logic [15:0] m_ret = '0, m_wbd = '0;
  logic m_pend = 1'b0, m_wbv = 1'b0, m_sig = 1'b0, m_op = 1'b0;
  logic [1:0] m_rd = '0, m_wba = '0, m_s1 = '0, m_s2 = '0;
  task automatic m_write(input logic [1:0] a, input logic [15:0] d);
    m_r[a] = d;
    m_wbv = 1'b1;
    m_wba = a;
    m_wbd = d;
    m_ret = m_ret + 16'd1;
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
      m_ret = '0; m_pend = 1'b0; m_wbv = 1'b0;
      m_s1 = '0; m_s2 = '0; m_sig = 1'b0; m_op = 1'b0;
    end else begin
      m_wbv = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0;
        if (!flush) m_write(m_rd, {8'h00, alu_out});
      end else if (instr_valid && !flush) begin
        if (instr[15:14] == 2'b00) begin
          m_pend = 1'b1; m_rd = instr[11:10];
          m_s1 = instr[9:8]; m_s2 = instr[7:6]; m_op = instr[13]; m_sig = instr[12];
        end else if (instr[15:14] == 2'b01) m_write(instr[11:10], {8'h00, instr[7:0]});
        else if (instr[15:14] == 2'b10) m_write(instr[11:10], {instr[7:0], m_r[instr[11:10]][7:0]});
        else m_ret = m_ret + 16'd1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", instr_ready, !m_pend && !flush);
      chk("regs", alu_R, {m_r[3], m_r[2], m_r[1], m_r[0]});
      chk("wb_valid", wb_valid, m_wbv);
      if (m_wbv) chk("wb", {wb_addr, wb_data}, {m_wba, m_wbd});
      chk("retired", retired, m_ret);
      chk("alu_ctl", {alu_sel1, alu_sel2, alu_sig, alu_op}, {m_s1, m_s2, m_sig, m_op});
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic [15:0] i, output int waits);
    bit r;
    instr = i;
    instr_valid = 1'b1;
    waits = 0;
    r = 1'b0;
    for (int k = 0; k < 6; k++) begin
      r = instr_ready;
      step();
      if (r) break;
      waits++;
    end
    chk("issue_accept", r, 1'b1);
  endtask
  initial begin
    int w;
    rst_n = 1'b0; instr = 16'hC000; instr_valid = 1'b0; flush = 1'b0; alu_out = 8'h00;
    instr4 = 16'hC000; valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_regs", alu_R, 64'h0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_wb", {wb_valid, wb_addr, wb_data}, 19'h0);
    chk("rst_ctl", {alu_sel1, alu_sel2, alu_sig, alu_op}, 6'h0);
    // LDL R2=A5 then LDH R2=3C back to back
    issue(16'h48A5, w);
    chk("ldl_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd2, 16'h00A5});
    issue(16'h883C, w);
    chk("ldh_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd2, 16'h3CA5});
    chk("ldh_r2", alu_R[2], 16'h3CA5);
    chk("ldh_retired", retired, 16'd2);
    // LDL R1 then ALUOP rd=3 rs1=1 rs2=2 op=0 sig=1 immediately after
    issue(16'h4411, w);
    alu_out = 8'h7E;
    issue(16'h1D80, w);
    instr_valid = 1'b0;
    chk("exec_ready", instr_ready, 1'b0);
    chk("exec_ctl", {alu_sel1, alu_sel2, alu_sig, alu_op}, 6'b01_10_1_0);
    chk("exec_r1", alu_R[1], 16'h0011);
    step();
    chk("alu_ready_back", instr_ready, 1'b1);
    chk("alu_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd3, 16'h007E});
    chk("alu_r3", alu_R[3], 16'h007E);
    // held-valid stream LDL, ALUOP, LDL
    alu_out = 8'hC3;
    issue(16'h4466, w);
    issue(16'h2180, w);
    issue(16'h4C55, w);
    chk("stream_wait", w, 1);
    chk("stream_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 2'd3, 16'h0055});
    chk("stream_r0", alu_R[0], 16'h00C3);
    chk("stream_retired", retired, 16'd7);
    instr_valid = 1'b0;
    // flush during EXEC
    alu_out = 8'h99;
    issue(16'h2180, w);
    instr_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_r0", alu_R[0], 16'h00C3);
    chk("flush_wb", wb_valid, 1'b0);
    chk("flush_ret", retired, 16'd7);
    // flush in IDLE blocks one acceptance only
    instr = 16'h4422; instr_valid = 1'b1; flush = 1'b1;
    chk("flush_idle_ready", instr_ready, 1'b0);
    step();
    chk("flush_idle_ret", retired, 16'd7);
    chk("flush_idle_wb", wb_valid, 1'b0);
    flush = 1'b0;
    step();
    instr_valid = 1'b0;
    chk("after_flush_r1", alu_R[1], 16'h0022);
    chk("after_flush_ret", retired, 16'd8);
    // asynchronous reset in the middle of EXEC
    issue(16'h1D80, w);
    instr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_regs", alu_R, 64'h0);
    chk("arst_ready", instr_ready, 1'b1);
    chk("arst_retired", retired, 16'h0);
    chk("arst_ctl", {alu_sel1, alu_sel2, alu_sig, alu_op}, 6'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_no_wb", {wb_valid, retired}, 17'h0);
    chk("arst_r3", alu_R[3], 16'h0000);
    // 4-bit retired counter wrap
    valid4 = 1'b1;
    repeat (14) step();
    chk("w4_e", ret4, 4'hE);
    step();
    chk("w4_f", {wbv4, ret4}, 5'h0F);
    step();
    chk("w4_0", {wbv4, ret4}, 5'h00);
    step();
    chk("w4_1", {wbv4, ret4}, 5'h01);
    valid4 = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
